bios_rom_seq: RTL and testbench

//  Parametrised boot ROM with a boot sequencer. Holds the boot image in a register array

---
 rtl/bios_rom_seq_pkg.sv | 45 ++++
 rtl/bios_rom_seq_if.sv | 27 ++
 rtl/bios_rom_seq_image.sv | 17 +
 rtl/bios_rom_seq.sv | 94 +++++++++
 tb/tb_bios_rom_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/bios_rom_seq_pkg.sv
// Shared definitions for the boot ROM: FSM states, opcode fields and the boot program.
package bios_rom_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_BOOT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [5:0] OP_LOADI  = 6'h01;
    localparam logic [5:0] OP_LOADHD = 6'h02;
    localparam logic [5:0] OP_RSTORE = 6'h03;
    localparam logic [5:0] OP_NOP    = 6'h1B;

    localparam logic [31:0] NOP_INSN = {OP_NOP, 26'd0};

    // Instruction layout: opcode[31:26], rd[25:21], unused[20:16], imm[15:0].
    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [15:0] imm);
        return {op, rd, 5'd0, imm};
    endfunction

    function automatic logic [31:0] boot_word(input int idx);
        case (idx)
            0:       return NOP_INSN;
            1:       return enc(OP_LOADI,  5'd1,  16'h0100);
            2:       return enc(OP_LOADI,  5'd2,  16'h0200);
            3:       return enc(OP_LOADHD, 5'd3,  16'h0001);
            4:       return enc(OP_RSTORE, 5'd3,  16'h0100);
            5:       return enc(OP_LOADI,  5'd4,  16'h1234);
            6:       return enc(OP_LOADHD, 5'd5,  16'h0002);
            7:       return enc(OP_RSTORE, 5'd5,  16'h0104);
            8:       return enc(OP_LOADI,  5'd6,  16'hBEEF);
            9:       return enc(OP_LOADHD, 5'd7,  16'h0003);
            10:      return enc(OP_RSTORE, 5'd7,  16'h0108);
            11:      return enc(OP_LOADI,  5'd8,  16'h0000);
            12:      return enc(OP_LOADHD, 5'd9,  16'h0004);
            13:      return enc(OP_RSTORE, 5'd9,  16'h010C);
            14:      return enc(OP_LOADI,  5'd10, 16'h0400);
            15:      return enc(OP_RSTORE, 5'd10, 16'h0110);
            default: return NOP_INSN;
        endcase
    endfunction

endpackage

// File: rtl/bios_rom_seq_if.sv
// Fetch and patch-write bus between the fetch stage and the boot ROM.
interface bios_rom_seq_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // fetch_req is taken on the clock edge with no ready; fetch_valid (with fetch_data and
    // fetch_oor) answers exactly one cycle later, and wr_err likewise pulses one cycle after a rejected wr_en.
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_oor;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_err;

    modport master (
        output fetch_req, fetch_addr, wr_en, wr_addr, wr_data,
        input  fetch_valid, fetch_data, fetch_oor, wr_err
    );

    modport slave (
        input  fetch_req, fetch_addr, wr_en, wr_addr, wr_data,
        output fetch_valid, fetch_data, fetch_oor, wr_err
    );
endinterface

// File: rtl/bios_rom_seq_image.sv
// Combinational boot image: every implemented entry's reset value, unused entries hold NOP.
module bios_rom_seq_image
    import bios_rom_seq_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 64,
    parameter int          BOOT_LEN = 18,
    parameter logic [31:0] NOP_WORD = NOP_INSN
) (
    output logic [DATA_W-1:0] words [DEPTH]
);
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = (i < BOOT_LEN) ? DATA_W'(boot_word(i)) : DATA_W'(NOP_WORD);
        end
    end
endmodule

// File: rtl/bios_rom_seq.sv
// Boot ROM with boot sequencer: registered 1-cycle fetch, post-boot patch writes, restart reload.
module bios_rom_seq
    import bios_rom_seq_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 10,
    parameter int          DEPTH    = 64,
    parameter int          BOOT_LEN = 18,
    parameter logic [31:0] NOP_WORD = NOP_INSN
) (
    input  logic           clock,
    input  logic           reset_n,
    bios_rom_seq_if.slave  bus,
    input  logic           boot_restart,
    output logic           boot_done,
    output state_t         state
);
    localparam int              IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(BOOT_LEN - 1);

    logic [DATA_W-1:0] image [DEPTH];
    logic [DATA_W-1:0] mem   [DEPTH];
    logic              fetch_in_range;
    logic              wr_in_range;
    logic              restart_now;
    logic              serving;
    logic              wr_accept;
    logic [IDX_W-1:0]  fetch_idx;
    logic [IDX_W-1:0]  wr_idx;

    bios_rom_seq_image #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .BOOT_LEN (BOOT_LEN),
        .NOP_WORD (NOP_WORD)
    ) u_image (
        .words (image)
    );

    assign fetch_in_range = {1'b0, bus.fetch_addr} < DEPTH_L;
    assign wr_in_range    = {1'b0, bus.wr_addr} < DEPTH_L;
    assign fetch_idx      = bus.fetch_addr[IDX_W-1:0];
    assign wr_idx         = bus.wr_addr[IDX_W-1:0];
    // A restart wins over a fetch or write presented in the same cycle.
    assign restart_now    = boot_restart && (state != ST_HOLD);
    assign serving        = bus.fetch_req && (state != ST_HOLD) && !restart_now;
    assign wr_accept      = bus.wr_en && (state == ST_DONE) && !restart_now && wr_in_range;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem <= image;
        end else if (restart_now) begin
            mem <= image;
        end else if (wr_accept) begin
            mem[wr_idx] <= bus.wr_data;
        end
    end

    // Reads sample mem before this edge's write lands, giving read-before-write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_HOLD;
            boot_done       <= 1'b0;
            bus.fetch_valid <= 1'b0;
            bus.fetch_data  <= DATA_W'(NOP_WORD);
            bus.fetch_oor   <= 1'b0;
            bus.wr_err      <= 1'b0;
        end else begin
            bus.fetch_valid <= serving;
            bus.fetch_oor   <= serving && !fetch_in_range;
            bus.wr_err      <= bus.wr_en && !wr_accept;
            if (serving) begin
                bus.fetch_data <= fetch_in_range ? mem[fetch_idx] : DATA_W'(NOP_WORD);
            end
            if (restart_now) begin
                state     <= ST_HOLD;
                boot_done <= 1'b0;
            end else begin
                case (state)
                    ST_HOLD: state <= ST_BOOT;
                    ST_BOOT: begin
                        if (serving && ({1'b0, bus.fetch_addr} == LAST_L)) begin
                            state     <= ST_DONE;
                            boot_done <= 1'b1;
                        end
                    end
                    ST_DONE: state <= ST_DONE;
                    default: state <= ST_HOLD;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bios_rom_seq.sv
// Self-checking bench for bios_rom_seq: directed vector table, reset/restart sequences, random vs model.
module tb_bios_rom_seq;
    import bios_rom_seq_pkg::*;

    localparam int          DATA_W   = 32;
    localparam int          ADDR_W   = 10;
    localparam int          DEPTH    = 64;
    localparam int          BOOT_LEN = 18;
    localparam logic [31:0] NOP      = 32'h6C000000;
    localparam logic [31:0] PATCH    = 32'hDEADBEEF;

    logic   clock = 1'b0;
    logic   reset_n = 1'b1;
    logic   boot_restart;
    logic   boot_done;
    state_t state;

    bios_rom_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bios_rom_seq #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .BOOT_LEN (BOOT_LEN),
        .NOP_WORD (NOP)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .boot_restart (boot_restart),
        .boot_done    (boot_done),
        .state        (state)
    );

    always #5 clock = ~clock;

    logic [31:0] img [BOOT_LEN] = '{
        32'h6C000000, 32'h04200100, 32'h04400200, 32'h08600001, 32'h0C600100, 32'h04801234,
        32'h08A00002, 32'h0CA00104, 32'h04C0BEEF, 32'h08E00003, 32'h0CE00108, 32'h05000000,
        32'h09200004, 32'h0D20010C, 32'h05400400, 32'h0D400110, 32'h6C000000, 32'h6C000000
    };

    typedef struct {
        logic        req;
        logic [9:0]  addr;
        logic        wr_en;
        logic [9:0]  wr_addr;
        logic [31:0] wr_data;
        logic        restart;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_oor;
        logic        e_err;
        logic        e_done;
    } vec_t;

    vec_t        vecs[$];
    int          n_prefix;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    logic [31:0] m_mem [DEPTH];
    logic        m_hold;
    logic        m_done;
    logic [31:0] m_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [9:0] addr, input logic wr_en,
                         input logic [9:0] wr_addr, input logic [31:0] wr_data, input logic restart);
        bus.fetch_req  = req;
        bus.fetch_addr = addr;
        bus.wr_en      = wr_en;
        bus.wr_addr    = wr_addr;
        bus.wr_data    = wr_data;
        boot_restart   = restart;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic req, input int addr, input logic wr_en, input int wr_addr,
                       input logic [31:0] wr_data, input logic restart, input logic e_valid,
                       input logic [31:0] e_data, input logic e_oor, input logic e_err,
                       input logic e_done);
        vec_t v;
        v.req = req; v.addr = 10'(addr); v.wr_en = wr_en; v.wr_addr = 10'(wr_addr);
        v.wr_data = wr_data; v.restart = restart; v.e_valid = e_valid; v.e_data = e_data;
        v.e_oor = e_oor; v.e_err = e_err; v.e_done = e_done;
        vecs.push_back(v);
    endtask

    task automatic run_vecs(input int first, input int last, input string tag);
        for (int i = first; i < last; i++) begin
            drive(vecs[i].req, vecs[i].addr, vecs[i].wr_en, vecs[i].wr_addr,
                  vecs[i].wr_data, vecs[i].restart);
            tick();
            check($sformatf("%s%0d_valid", tag, i), bus.fetch_valid, vecs[i].e_valid);
            check($sformatf("%s%0d_data", tag, i), bus.fetch_data, vecs[i].e_data);
            if (vecs[i].e_valid)
                check($sformatf("%s%0d_oor", tag, i), bus.fetch_oor, vecs[i].e_oor);
            check($sformatf("%s%0d_err", tag, i), bus.wr_err, vecs[i].e_err);
            check($sformatf("%s%0d_done", tag, i), boot_done, vecs[i].e_done);
        end
    endtask

    task automatic model_reload();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = (i < BOOT_LEN) ? img[i] : NOP;
    endtask

    task automatic random_phase(input int cycles);
        logic        req, wr_en, restart, was_done;
        logic [9:0]  addr, wr_addr;
        logic [31:0] wr_data, e_data, got;
        logic        e_valid, e_oor, e_err;
        for (int c = 0; c < cycles; c++) begin
            req     = ($urandom_range(0, 3) != 0);
            addr    = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(64, 1023))
                                                  : 10'($urandom_range(0, 19));
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 10'($urandom_range(0, 70));
            wr_data = $urandom;
            restart = ($urandom_range(0, 59) == 0);
            drive(req, addr, wr_en, wr_addr, wr_data, restart);

            e_valid = 1'b0; e_oor = 1'b0; e_err = 1'b0;
            was_done = m_done;
            if (m_hold) begin
                e_err  = wr_en;
                m_hold = 1'b0;
            end else if (restart) begin
                e_err  = wr_en;
                m_hold = 1'b1;
                m_done = 1'b0;
                model_reload();
            end else begin
                if (req) begin
                    e_valid = 1'b1;
                    if (addr < DEPTH) m_last = m_mem[addr];
                    else begin m_last = NOP; e_oor = 1'b1; end
                    exp_q.push_back(m_last);
                    if (addr == BOOT_LEN - 1) m_done = 1'b1;
                end
                if (wr_en) begin
                    if (was_done && wr_addr < DEPTH) m_mem[wr_addr] = wr_data;
                    else e_err = 1'b1;
                end
            end

            tick();
            check($sformatf("rnd%0d_valid", c), bus.fetch_valid, e_valid);
            if (e_valid) begin
                e_data = exp_q.pop_front();
                check($sformatf("rnd%0d_data", c), bus.fetch_data, e_data);
                check($sformatf("rnd%0d_oor", c), bus.fetch_oor, e_oor);
            end else begin
                got = bus.fetch_data;
                check($sformatf("rnd%0d_hold", c), got, m_last);
            end
            check($sformatf("rnd%0d_err", c), bus.wr_err, e_err);
            check($sformatf("rnd%0d_done", c), boot_done, m_done);
        end
    endtask

    initial begin
        // HOLD cycle ignores the request, then the boot program streams back-to-back.
        add(1, 0, 0, 0, 0, 0,  0, NOP, 0, 0, 0);
        for (int i = 0; i < BOOT_LEN; i++) begin
            add(1, i, (i == 4), 5, PATCH, 0,  1, img[i], 0, (i == 4), (i == BOOT_LEN - 1));
            if (i == 8) add(0, 0, 0, 0, 0, 0,  0, img[8], 0, 0, 0);
        end
        n_prefix = vecs.size();
        add(1, 64,   0, 0, 0, 0,  1, NOP, 1, 0, 1);
        add(1, 1023, 0, 0, 0, 0,  1, NOP, 1, 0, 1);
        add(1, 5,    1, 5, PATCH, 0,  1, img[5], 0, 0, 1);
        add(1, 5,    0, 0, 0, 0,  1, PATCH, 0, 0, 1);
        add(0, 0,    1, 64, PATCH, 0,  0, PATCH, 0, 1, 1);
        add(1, 5,    0, 0, 0, 1,  0, PATCH, 0, 0, 0);
        add(1, 5,    0, 0, 0, 0,  0, PATCH, 0, 0, 0);
        add(1, 5,    0, 0, 0, 0,  1, img[5], 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #2;
        check("reset_valid", bus.fetch_valid, 1'b0);
        check("reset_data", bus.fetch_data, NOP);
        check("reset_oor", bus.fetch_oor, 1'b0);
        check("reset_err", bus.wr_err, 1'b0);
        check("reset_done", boot_done, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        run_vecs(0, vecs.size(), "vec");

        // Finish a boot, then abort a fetch with reset between edges.
        for (int i = 0; i < BOOT_LEN; i++) begin
            drive(1, 10'(i), 0, 0, 0, 0);
            tick();
        end
        check("burst_done", boot_done, 1'b1);
        drive(1, 10'd3, 0, 0, 0, 0);
        tick();
        check("burst_valid", bus.fetch_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("abort_valid", bus.fetch_valid, 1'b0);
        check("abort_done", boot_done, 1'b0);
        check("abort_data", bus.fetch_data, NOP);
        @(negedge clock) reset_n = 1'b1;
        run_vecs(0, n_prefix, "rerun");

        drive(0, 0, 0, 0, 0, 0);
        @(negedge clock) reset_n = 1'b0;
        @(negedge clock) reset_n = 1'b1;
        model_reload();
        m_hold = 1'b1;
        m_done = 1'b0;
        m_last = NOP;
        exp_q.delete();
        random_phase(800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
